// File: rtl/reg_bus_pkg.sv
// Shared defaults and FSM state encoding for the register-bus initiator.
package reg_bus_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  localparam logic [15:0] RESET_VAL = 16'h1234;

  typedef enum logic [1:0] {IDLE, REQ, RD_WAIT, RSP} reg_mst_state_e;
endpackage

// File: rtl/reg_ctrl_master_if.sv
// Command, response and register-bus signals of one reg_ctrl_master instance.
interface reg_ctrl_master_if #(
  parameter int AW = reg_bus_pkg::ADDR_WIDTH,
  parameter int DW = reg_bus_pkg::DATA_WIDTH
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          sel;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rdata, ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel, wr, addr, wdata
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rdata, ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel, wr, addr, wdata
  );
endinterface

// File: rtl/reg_ctrl_master.sv
// Single-outstanding initiator: turns upstream commands into sel/wr bus cycles
// and returns one response (read data or write ack, plus error) per command.
module reg_ctrl_master #(
  parameter int ADDR_WIDTH = reg_bus_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = reg_bus_pkg::DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst,
  reg_ctrl_master_if.master  bus
);
  import reg_bus_pkg::*;

  localparam int TW = $clog2(TIMEOUT) + 1;

  reg_mst_state_e        r_state;
  logic [TW-1:0]         r_tcnt;
  logic                  r_sel;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.sel       = r_sel;
  assign bus.wr        = r_wr;
  assign bus.addr      = r_addr;
  assign bus.wdata     = r_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tcnt      <= '0;
      r_sel       <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_wr    <= bus.cmd_wr;
            r_addr  <= bus.cmd_addr;
            r_wdata <= bus.cmd_wdata;
            r_sel   <= 1'b1;
            r_tcnt  <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (bus.ready) begin
            if (r_wr) begin
              r_sel       <= 1'b0;
              r_wr        <= 1'b0;
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= RSP;
            end else begin
              // sel stays high so the responder can re-arm during RD_WAIT
              r_state <= RD_WAIT;
            end
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_sel       <= 1'b0;
            r_wr        <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        RD_WAIT: begin
          // ready still high here means the responder skipped its re-arm cycle
          r_rsp_rdata <= bus.ready ? '0 : bus.rdata;
          r_rsp_err   <= bus.ready;
          r_sel       <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_ctrl_master.sv
// Directed bench: reg_ctrl_master against a small behavioural register responder.
module tb_reg_ctrl_master;
  import reg_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_ctrl_master_if #(.AW(8), .DW(16)) bus_if ();

  reg_ctrl_master #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // responder model: ready drops for one cycle after each accept, reg file resets to RESET_VAL
  logic        rs_ready;
  logic        stub_hold = 1'b0;
  logic [15:0] mem [256];

  assign bus_if.ready = stub_hold ? 1'b0 : rs_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_ready     <= 1'b1;
      bus_if.rdata <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= RESET_VAL;
    end else if (bus_if.sel && bus_if.ready) begin
      rs_ready <= 1'b0;
      if (bus_if.wr) mem[bus_if.addr] <= bus_if.wdata;
      else           bus_if.rdata     <= mem[bus_if.addr];
    end else begin
      rs_ready <= 1'b1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // drive one command, return at the negedge where rsp_valid is first seen
  task automatic issue(input logic wr, input logic [7:0] a, input logic [15:0] d, output int lat);
    int t;
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_wr    = wr;
    bus_if.cmd_addr  = a;
    bus_if.cmd_wdata = d;
    t = 0;
    while (!bus_if.cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!bus_if.cmd_ready) chk("cmd_ready_wait", 32'(bus_if.cmd_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    while (!bus_if.rsp_valid && lat < 64) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (!bus_if.rsp_valid) chk("rsp_valid_wait", 32'(bus_if.rsp_valid), 32'd1);
  endtask

  task automatic take_rsp();
    @(posedge clk);
    @(negedge clk);
  endtask

  int          lat;
  logic [15:0] q [$];
  logic [15:0] held;
  int          runs;
  logic        prev_sel, drop;

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_wr    = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_wdata = '0;
    bus_if.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_sel",       32'(bus_if.sel),       32'd0);
    chk("rst_wr",        32'(bus_if.wr),        32'd0);
    chk("rst_addr",      32'(bus_if.addr),      32'd0);
    chk("rst_wdata",     32'(bus_if.wdata),     32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    chk("rst_rsp_err",   32'(bus_if.rsp_err),   32'd0);
    chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    rst = 1'b0;

    // 1: read of a reset-valued register
    issue(1'b0, 8'h20, 16'h0, lat);
    chk("t1_lat",   32'(lat),              32'd3);
    chk("t1_rdata", 32'(bus_if.rsp_rdata), 32'h1234);
    chk("t1_err",   32'(bus_if.rsp_err),   32'd0);
    chk("t1_sel",   32'(bus_if.sel),       32'd0);
    take_rsp();
    chk("t1_taken", 32'(bus_if.rsp_valid), 32'd0);
    chk("t1_idle",  32'(bus_if.cmd_ready), 32'd1);

    // 2: write then read back
    issue(1'b1, 8'h10, 16'hBEEF, lat);
    chk("t2_wlat",   32'(lat),              32'd2);
    chk("t2_wrdata", 32'(bus_if.rsp_rdata), 32'd0);
    chk("t2_werr",   32'(bus_if.rsp_err),   32'd0);
    take_rsp();
    issue(1'b0, 8'h10, 16'h0, lat);
    chk("t2_rlat",   32'(lat),              32'd3);
    chk("t2_rdata",  32'(bus_if.rsp_rdata), 32'hBEEF);
    take_rsp();

    // 3: back-to-back reads with cmd_valid held
    issue(1'b1, 8'h01, 16'hAAAA, lat); take_rsp();
    issue(1'b1, 8'h02, 16'h5555, lat); take_rsp();
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_wr    = 1'b0;
    bus_if.cmd_addr  = 8'h01;
    @(posedge clk);
    @(negedge clk);
    bus_if.cmd_addr = 8'h02;
    runs = 0; prev_sel = 1'b0; drop = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (drop) bus_if.cmd_valid = 1'b0;
      if (bus_if.sel && !prev_sel) runs++;
      prev_sel = bus_if.sel;
      if (bus_if.rsp_valid) q.push_back(bus_if.rsp_rdata);
      if (q.size() == 2) break;
      if (q.size() == 1 && bus_if.cmd_ready && bus_if.cmd_valid) drop = 1'b1;
    end
    bus_if.cmd_valid = 1'b0;
    chk("t3_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      chk("t3_first",  32'(q[0]), 32'hAAAA);
      chk("t3_second", 32'(q[1]), 32'h5555);
    end
    chk("t3_sel_runs", 32'(runs),     32'd2);
    chk("t3_rs_ready", 32'(rs_ready), 32'd1);
    take_rsp();

    // 4: response backpressure
    bus_if.rsp_ready = 1'b0;
    issue(1'b0, 8'h10, 16'h0, lat);
    held = bus_if.rsp_rdata;
    chk("t4_rdata", 32'(held), 32'hBEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t4_hold", {bus_if.rsp_valid, bus_if.cmd_ready, bus_if.sel, bus_if.rsp_err, bus_if.rsp_rdata},
          {4'b1000, held});
    end
    bus_if.rsp_ready = 1'b1;
    take_rsp();
    chk("t4_release", {bus_if.rsp_valid, bus_if.cmd_ready}, 32'b01);

    // 5: responder never ready -> timeout
    stub_hold = 1'b1;
    issue(1'b0, 8'h30, 16'h0, lat);
    chk("t5_lat",   32'(lat),              32'd17);
    chk("t5_err",   32'(bus_if.rsp_err),   32'd1);
    chk("t5_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    take_rsp();
    repeat (2) @(negedge clk);
    chk("t5_sel", 32'(bus_if.sel), 32'd0);
    stub_hold = 1'b0;

    // 6: reset while waiting for read data
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_wr    = 1'b0;
    bus_if.cmd_addr  = 8'h10;
    @(posedge clk);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_sel_before", 32'(bus_if.sel), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_sel_async",   32'(bus_if.sel),       32'd0);
    chk("t6_valid_async", 32'(bus_if.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 8'h10, 16'h0, lat);
    chk("t6_rdata", 32'(bus_if.rsp_rdata), 32'h1234);
    chk("t6_err",   32'(bus_if.rsp_err),   32'd0);
    take_rsp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
